// File: rtl/mesh_pkg.sv
// Shared mesh definitions: write-request record and default sizes for msh_wr_in.
package mesh_pkg;

  localparam int MSH_WR_IN_DEPTH = 8;
  localparam int MSH_WR_ADDR_W   = 20;
  localparam int MSH_WR_DATA_W   = 64;

  // One buffered write request; address sits above data when packed.
  typedef struct packed {
    logic [MSH_WR_ADDR_W-1:0] addr;
    logic [MSH_WR_DATA_W-1:0] data;
  } msh_wr_req_t;

endpackage

// File: rtl/msh_wr_in_fifo.sv
// Storage and pointer logic for the msh_wr_in request buffer.
// Pointers carry one extra wrap bit: equal pointers mean empty, equal index
// with differing wrap bit means full. Storage is deliberately not reset.
module msh_wr_in_fifo
  import mesh_pkg::*;
#(
  parameter int DEPTH = MSH_WR_IN_DEPTH,
  parameter int W     = $bits(msh_wr_req_t)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

  // A push into a full buffer is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = mem[rd_ptr[IW-1:0]];

  // Entry storage: written at the tail, no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[IW-1:0]] <= wdata;
    end
  end

  // Pointer registers; power-of-two depth makes the wrap bit toggle naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/msh_wr_in.sv
// Mesh write-request ingress buffer. Upstream pushes under credit control (no
// back-pressure); each pop toward msh_wr_dp returns one credit a cycle later.
// Handshake: downstream transfer happens on a cycle where o_wr_vld & i_wr_rdy;
// the head stays stable while o_wr_vld=1 and i_wr_rdy=0. Upstream i_wr_vld
// is a push with no ready; pushing into a full buffer without a pop is dropped
// and sets the sticky o_ovf_err.
// Optional feature: define MSH_WR_IN_BYPASS_EN for a zero-latency path when
// the buffer is empty. Default build has a fixed one-cycle latency.
module msh_wr_in
  import mesh_pkg::*;
#(
  parameter int DEPTH  = MSH_WR_IN_DEPTH,
  parameter int ADDR_W = MSH_WR_ADDR_W,
  parameter int DATA_W = MSH_WR_DATA_W
) (
  input  logic                     mclk,
  input  logic                     mrst_n,
  input  logic                     i_wr_vld,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  output logic                     o_crd_rtn,
  output logic                     o_wr_vld,
  output logic [ADDR_W-1:0]        o_wr_addr,
  output logic [DATA_W-1:0]        o_wr_data,
  input  logic                     i_wr_rdy,
  output logic [$clog2(DEPTH):0]   o_occ,
  output logic                     o_ovf_err
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int W  = ADDR_W + DATA_W;

  logic [W-1:0]  head;
  logic          empty;
  logic          full;
  logic          pop;
  logic          store;
  logic          drop;
  logic          byp_take;
  logic [PW-1:0] occ_q;
  logic          crd_q;
  logic          ovf_q;

  // Only a stored head can be popped; i_wr_rdy is ignored while empty.
  assign pop = ~empty & i_wr_rdy;

`ifdef MSH_WR_IN_BYPASS_EN
  // Empty buffer and an accepting consumer: the request flies straight through.
  assign byp_take = i_wr_vld & empty & i_wr_rdy;

  // Present the incoming request directly when nothing is queued.
  always_comb begin
    o_wr_vld               = ~empty | i_wr_vld;
    {o_wr_addr, o_wr_data} = head;
    if (empty) begin
      o_wr_addr = i_wr_addr;
      o_wr_data = i_wr_data;
    end
  end
`else
  assign byp_take = 1'b0;

  // Outputs come only from registered storage: no input-to-output path.
  always_comb begin
    o_wr_vld               = ~empty;
    {o_wr_addr, o_wr_data} = head;
  end
`endif

  assign store = i_wr_vld & ~byp_take & (~full | pop);
  assign drop  = i_wr_vld & full & ~pop;

  msh_wr_in_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (mclk),
    .rst_n (mrst_n),
    .push  (store),
    .pop   (pop),
    .wdata ({i_wr_addr, i_wr_data}),
    .rdata (head),
    .empty (empty),
    .full  (full)
  );

  // Occupancy, credit-return pulse and sticky overflow flag.
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      occ_q <= '0;
      crd_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case ({store, pop})
        2'b10:   occ_q <= occ_q + PW'(1);
        2'b01:   occ_q <= occ_q - PW'(1);
        default: occ_q <= occ_q;
      endcase
      crd_q <= pop | byp_take;
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign o_occ     = occ_q;
  assign o_crd_rtn = crd_q;
  assign o_ovf_err = ovf_q;

endmodule

// File: tb/tb_msh_wr_in.sv
// Self-checking bench for msh_wr_in (default build or MSH_WR_IN_BYPASS_EN).
module tb_msh_wr_in;

  localparam int DEPTH = 8;
  localparam int AW    = 20;
  localparam int DW    = 64;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          mclk;
  logic          mrst_n;
  logic          i_wr_vld;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic          o_crd_rtn;
  logic          o_wr_vld;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic          i_wr_rdy;
  logic [PW-1:0] o_occ;
  logic          o_ovf_err;

  logic [AW+DW-1:0] exp_q[$];
  int n_chk;
  int n_fail;
  int crd_cnt;
  int pop_cnt;
  bit ovf_exp;

  msh_wr_in #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .mclk      (mclk),
    .mrst_n    (mrst_n),
    .i_wr_vld  (i_wr_vld),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .o_crd_rtn (o_crd_rtn),
    .o_wr_vld  (o_wr_vld),
    .o_wr_addr (o_wr_addr),
    .o_wr_data (o_wr_data),
    .i_wr_rdy  (i_wr_rdy),
    .o_occ     (o_occ),
    .o_ovf_err (o_ovf_err)
  );

  // Clock and global time limit.
  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Drive one cycle at the falling edge, check mid-cycle, update the model.
  task automatic step(input logic vld, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic rdy);
    logic [AW+DW-1:0] exp;
    bit pushed;
    @(negedge mclk);
    i_wr_vld  = vld;
    i_wr_addr = a;
    i_wr_data = d;
    i_wr_rdy  = rdy;
    #2;
    n_chk++;
    if (o_occ !== PW'(exp_q.size())) begin
      n_fail++;
      $display("FAIL occ: got %0d, required %0d", o_occ, exp_q.size());
    end
    n_chk++;
    if (o_ovf_err !== ovf_exp) begin
      n_fail++;
      $display("FAIL ovf_err: got %b, required %b", o_ovf_err, ovf_exp);
    end
    if (o_crd_rtn === 1'b1) crd_cnt++;
    pushed = 0;
`ifdef MSH_WR_IN_BYPASS_EN
    if (vld && exp_q.size() == 0) begin
      exp_q.push_back({a, d});
      pushed = 1;
    end
`endif
    n_chk++;
    if (o_wr_vld !== (exp_q.size() != 0)) begin
      n_fail++;
      $display("FAIL wr_vld: got %b, required %b", o_wr_vld, exp_q.size() != 0);
    end
    if (o_wr_vld === 1'b1 && rdy) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_empty: got pop of %h, required no entry", {o_wr_addr, o_wr_data});
      end else begin
        exp = exp_q.pop_front();
        if ({o_wr_addr, o_wr_data} !== exp) begin
          n_fail++;
          $display("FAIL head: got %h, required %h", {o_wr_addr, o_wr_data}, exp);
        end
      end
      pop_cnt++;
    end
    if (vld && !pushed) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({a, d});
      else ovf_exp = 1;
    end
  endtask

  task automatic test_reset();
    mrst_n    = 1'b0;
    i_wr_vld  = 1'b0;
    i_wr_addr = '0;
    i_wr_data = '0;
    i_wr_rdy  = 1'b0;
    exp_q.delete();
    ovf_exp = 0;
    repeat (3) @(negedge mclk);
    #2;
    n_chk += 4;
    if (o_wr_vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld: got %b, required 0", o_wr_vld); end
    if (o_occ !== '0)      begin n_fail++; $display("FAIL rst_occ: got %0d, required 0", o_occ); end
    if (o_crd_rtn !== 1'b0) begin n_fail++; $display("FAIL rst_crd: got %b, required 0", o_crd_rtn); end
    if (o_ovf_err !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b, required 0", o_ovf_err); end
    @(negedge mclk);
    mrst_n = 1'b1;
  endtask

  task automatic test_fill();
    int crd0;
    crd0 = crd_cnt;
    for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(20'h01000 + i), {32'hA5A50000 + i, $urandom}, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    n_chk += 4;
    if (o_occ !== PW'(DEPTH)) begin n_fail++; $display("FAIL fill_occ: got %0d, required %0d", o_occ, DEPTH); end
    if (o_wr_vld !== 1'b1) begin n_fail++; $display("FAIL fill_vld: got %b, required 1", o_wr_vld); end
    if (o_wr_addr !== 20'h01000) begin n_fail++; $display("FAIL fill_head: got %h, required 01000", o_wr_addr); end
    if (crd_cnt != crd0) begin n_fail++; $display("FAIL fill_crd: got %0d pulses, required 0", crd_cnt - crd0); end
  endtask

  task automatic test_full_stream();
    int crd0;
    crd0 = crd_cnt;
    for (int i = 0; i < 20; i++) step(1'b1, AW'(20'h02000 + i), {$urandom, $urandom}, 1'b1);
    step(1'b0, '0, '0, 1'b0);
    n_chk += 3;
    if (o_occ !== PW'(DEPTH)) begin n_fail++; $display("FAIL stream_occ: got %0d, required %0d", o_occ, DEPTH); end
    if (crd_cnt - crd0 != 20) begin n_fail++; $display("FAIL stream_crd: got %0d, required 20", crd_cnt - crd0); end
    if (o_ovf_err !== 1'b0) begin n_fail++; $display("FAIL stream_ovf: got %b, required 0", o_ovf_err); end
  endtask

  task automatic test_overflow();
    bit bad_seen;
    bad_seen = 0;
    step(1'b1, 20'hDEAD0, 64'hBAD0BAD0BAD0BAD0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    n_chk += 2;
    if (o_ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b, required 1", o_ovf_err); end
    if (o_occ !== PW'(DEPTH)) begin n_fail++; $display("FAIL ovf_occ: got %0d, required %0d", o_occ, DEPTH); end
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) begin
      step(1'b0, '0, '0, 1'b1);
      if (o_wr_vld === 1'b1 && o_wr_addr === 20'hDEAD0) bad_seen = 1;
    end
    step(1'b0, '0, '0, 1'b0);
    n_chk += 4;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovf_drain: got %0d left, required 0", exp_q.size()); end
    if (bad_seen) begin n_fail++; $display("FAIL ovf_dropped: got dropped addr DEAD0 on output, required never"); end
    if (o_wr_vld !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b, required 0", o_wr_vld); end
    if (o_ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b, required 1", o_ovf_err); end
  endtask

  task automatic test_reset_mid();
    int crd0;
    int pop0;
    for (int i = 0; i < 3; i++) step(1'b1, AW'(20'h03000 + i), {$urandom, $urandom}, 1'b0);
    @(negedge mclk);
    i_wr_vld = 1'b0;
    #2;
    mrst_n = 1'b0;
    #1;
    n_chk += 4;
    if (o_wr_vld !== 1'b0) begin n_fail++; $display("FAIL mid_vld: got %b, required 0", o_wr_vld); end
    if (o_occ !== '0)      begin n_fail++; $display("FAIL mid_occ: got %0d, required 0", o_occ); end
    if (o_crd_rtn !== 1'b0) begin n_fail++; $display("FAIL mid_crd: got %b, required 0", o_crd_rtn); end
    if (o_ovf_err !== 1'b0) begin n_fail++; $display("FAIL mid_ovf: got %b, required 0", o_ovf_err); end
    exp_q.delete();
    ovf_exp = 0;
    @(negedge mclk);
    mrst_n = 1'b1;
    crd0 = crd_cnt;
    pop0 = pop_cnt;
    repeat (3) step(1'b0, '0, '0, 1'b1);
    n_chk += 2;
    if (crd_cnt != crd0) begin n_fail++; $display("FAIL mid_nocrd: got %0d pulses, required 0", crd_cnt - crd0); end
    if (pop_cnt != pop0) begin n_fail++; $display("FAIL mid_nopop: got %0d pops, required 0", pop_cnt - pop0); end
  endtask

  task automatic test_wrap();
    int crd0;
    int pop0;
    int pushed;
    logic vld;
    crd0   = crd_cnt;
    pop0   = pop_cnt;
    pushed = 0;
    for (int cyc = 0; cyc < 3000 && (pushed < 37 || exp_q.size() > 0); cyc++) begin
      vld = (pushed < 37) && (exp_q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      step(vld, AW'(20'h20000 + pushed), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      if (vld) pushed++;
    end
    step(1'b0, '0, '0, 1'b0);
    n_chk += 4;
    if (pop_cnt - pop0 != 37) begin n_fail++; $display("FAIL wrap_pops: got %0d, required 37", pop_cnt - pop0); end
    if (crd_cnt - crd0 != 37) begin n_fail++; $display("FAIL wrap_crd: got %0d, required 37", crd_cnt - crd0); end
    if (o_ovf_err !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: got %b, required 0", o_ovf_err); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_left: got %0d, required 0", exp_q.size()); end
  endtask

`ifdef MSH_WR_IN_BYPASS_EN
  task automatic test_bypass();
    @(negedge mclk);
    i_wr_vld  = 1'b1;
    i_wr_addr = 20'h00AB5;
    i_wr_data = 64'h0123456789ABCDEF;
    i_wr_rdy  = 1'b1;
    #2;
    n_chk += 4;
    if (o_wr_vld !== 1'b1) begin n_fail++; $display("FAIL byp_vld: got %b, required 1", o_wr_vld); end
    if (o_wr_addr !== 20'h00AB5) begin n_fail++; $display("FAIL byp_addr: got %h, required 00ab5", o_wr_addr); end
    if (o_wr_data !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL byp_data: got %h, required 0123456789abcdef", o_wr_data); end
    if (o_occ !== '0) begin n_fail++; $display("FAIL byp_occ0: got %0d, required 0", o_occ); end
    @(negedge mclk);
    i_wr_vld = 1'b0;
    i_wr_rdy = 1'b0;
    #2;
    n_chk += 3;
    if (o_crd_rtn !== 1'b1) begin n_fail++; $display("FAIL byp_crd: got %b, required 1", o_crd_rtn); end
    if (o_occ !== '0) begin n_fail++; $display("FAIL byp_occ1: got %0d, required 0", o_occ); end
    if (o_wr_vld !== 1'b0) begin n_fail++; $display("FAIL byp_empty: got %b, required 0", o_wr_vld); end
    // Bypass with a stalled consumer stores the entry normally.
    step(1'b1, 20'h00AB6, 64'h1111, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);
  endtask
`endif

  // Test sequence and final report.
  initial begin
    n_chk   = 0;
    n_fail  = 0;
    crd_cnt = 0;
    pop_cnt = 0;
    ovf_exp = 0;
    test_reset();
    test_fill();
    test_full_stream();
    test_overflow();
    test_reset_mid();
    test_wrap();
`ifdef MSH_WR_IN_BYPASS_EN
    test_bypass();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
